// File: rtl/fma_pkg.sv
// Shared constants, types and the binary32 round/pack helper used by the
// fma accumulator result path.
package fma_pkg;

    localparam int LANES    = 4;
    localparam int LANE_W   = 2;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int BIAS     = 127;
    localparam int EXP_MAX  = (1 << EXP_W) - 1;
    localparam int ACC_W    = 32;
    localparam int AEXP_W   = 10;
    localparam int FRAC_POS = 30;
    localparam int LZ_W     = 6;
    // exponent shift when the mantissa MSB is moved to bit ACC_W-1
    localparam int NORM_OFS = ACC_W - 1 - FRAC_POS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                     sign;
        logic [ACC_W-1:0]         norm;
        logic signed [AEXP_W:0]   e;
        logic                     zero;
    } s1_t;

    // Round-to-nearest-even on the normalized mantissa, then range-check and pack.
    function automatic logic [31:0] pack_binary32(input s1_t s, input logic sat_inf,
                                                  input logic flush_en);
        logic [MAN_W-1:0]        mant;
        logic                    guard;
        logic                    sticky;
        logic                    rnd;
        logic [MAN_W:0]          mant_rnd;
        logic signed [AEXP_W+1:0] e;
        logic [31:0]             res;
        mant     = s.norm[FRAC_POS -: MAN_W];
        guard    = s.norm[FRAC_POS-MAN_W];
        sticky   = |s.norm[FRAC_POS-MAN_W-1:0];
        rnd      = guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {{MAN_W{1'b0}}, rnd};
        e        = $signed({s.e[AEXP_W], s.e}) + $signed({{(AEXP_W+1){1'b0}}, mant_rnd[MAN_W]});
        if (s.zero) begin
            res = 32'h0000_0000;
        end else if (flush_en && (e <= 12'sd0)) begin
            res = {s.sign, 31'd0};
        end else if (e >= 12'sd255) begin
            if (sat_inf) begin
                res = {s.sign, 8'hFF, 23'd0};
            end else begin
                res = {s.sign, 8'(2 * BIAS), 23'h7F_FFFF};
            end
        end else begin
            res = {s.sign, e[EXP_W-1:0], mant_rnd[MAN_W-1:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/fma_acc_lzc.sv
// 32-bit leading-zero counter; an all-zero input reports 32.
module fma_acc_lzc
    import fma_pkg::*;
(
    input  logic [ACC_W-1:0] val,
    output logic [LZ_W-1:0]  cnt
);

    // highest set bit wins because later iterations override earlier ones
    always_comb begin
        cnt = 6'd32;
        for (int i = 0; i < ACC_W; i++) begin
            cnt = val[i] ? 6'(ACC_W - 1 - i) : cnt;
        end
    end

endmodule

// File: rtl/fma_acc_pack.sv
// Captures the four accumulator lanes in one handshake, then normalizes,
// rounds and streams them out as binary32, one lane per cycle.
module fma_acc_pack
    import fma_pkg::*;
#(
    parameter int FLUSH_DENORM = 1,
    parameter int SAT_INF      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] acc0,
    input  logic [31:0] acc1,
    input  logic [31:0] acc2,
    input  logic [31:0] acc3,
    input  logic [9:0]  exp0,
    input  logic [9:0]  exp1,
    input  logic [9:0]  exp2,
    input  logic [9:0]  exp3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_lane,
    output logic        out_last
);

    state_t                   state_r;
    logic [LANE_W-1:0]        lane_r;
    logic                     in_ready_r;
    logic [ACC_W-1:0]         cap_acc_r [LANES];
    logic [AEXP_W-1:0]        cap_exp_r [LANES];

    s1_t                      s1_r;
    logic                     s1_valid_r;
    logic [LANE_W-1:0]        s1_lane_r;

    logic                     out_valid_r;
    logic [31:0]              out_data_r;
    logic [LANE_W-1:0]        out_lane_r;
    logic                     out_last_r;

    logic                     stall_s;
    logic                     issue_s;
    logic [ACC_W-1:0]         cur_acc_s;
    logic [AEXP_W-1:0]        cur_exp_s;
    logic [ACC_W-1:0]         mag_s;
    logic [LZ_W-1:0]          lz_s;
    logic signed [AEXP_W+1:0] e_wide_s;
    s1_t                      s1_next_s;

    assign stall_s = out_valid_r & ~out_ready;
    assign issue_s = (state_r == RUN) & ~stall_s;

    fma_acc_lzc u_lzc (
        .val (mag_s),
        .cnt (lz_s)
    );

    // Stage1 datapath: select the current lane, take |acc|, normalize, derive exponent.
    always_comb begin
        cur_acc_s = cap_acc_r[lane_r];
        cur_exp_s = cap_exp_r[lane_r];
        mag_s     = cur_acc_s[ACC_W-1] ? (~cur_acc_s + 32'd1) : cur_acc_s;
        e_wide_s  = $signed({2'b00, cur_exp_s}) + $signed((AEXP_W+2)'(NORM_OFS))
                  - $signed({{(AEXP_W+2-LZ_W){1'b0}}, lz_s});
        s1_next_s.sign = cur_acc_s[ACC_W-1];
        s1_next_s.norm = mag_s << lz_s;
        s1_next_s.zero = (mag_s == 32'd0);
        // only exp=1023 with acc=0x80000000 exceeds the 11-bit range; it overflows anyway
        if (e_wide_s > 12'sd1023) begin
            s1_next_s.e = 11'sd1023;
        end else begin
            s1_next_s.e = e_wide_s[AEXP_W:0];
        end
    end

    // Control FSM: bank capture, lane sequencing and registered in_ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            lane_r     <= 2'd0;
            in_ready_r <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                cap_acc_r[i] <= {ACC_W{1'b0}};
                cap_exp_r[i] <= {AEXP_W{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        cap_acc_r[0] <= acc0;
                        cap_acc_r[1] <= acc1;
                        cap_acc_r[2] <= acc2;
                        cap_acc_r[3] <= acc3;
                        cap_exp_r[0] <= exp0;
                        cap_exp_r[1] <= exp1;
                        cap_exp_r[2] <= exp2;
                        cap_exp_r[3] <= exp3;
                        lane_r       <= 2'd0;
                        in_ready_r   <= 1'b0;
                        state_r      <= RUN;
                    end else begin
                        in_ready_r   <= 1'b1;
                    end
                end
                RUN: begin
                    if (!stall_s) begin
                        lane_r <= lane_r + 2'd1;
                        if (lane_r == 2'd3) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // leave once lane 3 is handing off this cycle so the next bank is not delayed
                    if (!s1_valid_r && (!out_valid_r || out_ready)) begin
                        state_r    <= IDLE;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage pipeline; a stalled output register freezes both stages.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_r        <= '{sign: 1'b0, norm: 32'd0, e: 11'sd0, zero: 1'b0};
            s1_valid_r  <= 1'b0;
            s1_lane_r   <= 2'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'd0;
            out_lane_r  <= 2'd0;
            out_last_r  <= 1'b0;
        end else if (!stall_s) begin
            s1_r        <= s1_next_s;
            s1_valid_r  <= issue_s;
            s1_lane_r   <= lane_r;
            out_valid_r <= s1_valid_r;
            out_data_r  <= pack_binary32(s1_r, SAT_INF != 0, FLUSH_DENORM != 0);
            out_lane_r  <= s1_lane_r;
            out_last_r  <= s1_valid_r && (s1_lane_r == 2'd3);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_lane  = out_lane_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_fma_acc_pack.sv
// Self-checking bench for fma_acc_pack: vector table plus scoreboard, with
// hand-written latency, backpressure, reset and back-to-back sequences.
module tb_fma_acc_pack;

    typedef struct packed {
        logic [3:0][31:0] acc;
        logic [3:0][9:0]  ex;
        logic [3:0][31:0] r1;
        logic [3:0][31:0] r0;
    } vec_t;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d0;
        logic [1:0]  lane;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] acc_d [4];
    logic [9:0]  exp_d [4];
    logic        in_ready, out_valid, out_last;
    logic [31:0] out_data;
    logic [1:0]  out_lane;
    logic        ns_in_ready, ns_out_valid, ns_out_last;
    logic [31:0] ns_out_data;
    logic [1:0]  ns_out_lane;

    vec_t vecs [5];
    sb_t  sb [$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_hs_cyc = -100;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fma_acc_pack #(.FLUSH_DENORM(1), .SAT_INF(1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .acc0(acc_d[0]), .acc1(acc_d[1]), .acc2(acc_d[2]), .acc3(acc_d[3]),
        .exp0(exp_d[0]), .exp1(exp_d[1]), .exp2(exp_d[2]), .exp3(exp_d[3]),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .out_last(out_last)
    );

    fma_acc_pack #(.FLUSH_DENORM(1), .SAT_INF(0)) u_dut_ns (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ns_in_ready),
        .acc0(acc_d[0]), .acc1(acc_d[1]), .acc2(acc_d[2]), .acc3(acc_d[3]),
        .exp0(exp_d[0]), .exp1(exp_d[1]), .exp2(exp_d[2]), .exp3(exp_d[3]),
        .out_valid(ns_out_valid), .out_ready(out_ready), .out_data(ns_out_data),
        .out_lane(ns_out_lane), .out_last(ns_out_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int vi, input int ln, input logic [31:0] a, input logic [9:0] e,
                       input logic [31:0] r1, input logic [31:0] r0);
        vecs[vi].acc[ln] = a;
        vecs[vi].ex[ln]  = e;
        vecs[vi].r1[ln]  = r1;
        vecs[vi].r0[ln]  = r0;
    endtask

    // Drive a bank, wait (bounded) for the accepting edge, push expectations.
    task automatic send_bank(input int vi, input bit keep_valid, output int acc_cyc);
        bit done = 1'b0;
        int waited = 0;
        for (int k = 0; k < 4; k++) begin
            acc_d[k] = vecs[vi].acc[k];
            exp_d[k] = vecs[vi].ex[k];
        end
        in_valid = 1'b1;
        while (!done && waited < 40) begin
            done = in_ready;
            step();
            waited++;
        end
        acc_cyc = cyc;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no in_ready want accept of bank %0d", vi);
        end else begin
            for (int k = 0; k < 4; k++) begin
                sb.push_back('{d1: vecs[vi].r1[k], d0: vecs[vi].r0[k], lane: 2'(k)});
            end
        end
        if (!keep_valid) begin
            in_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                acc_d[k] = $urandom();
                exp_d[k] = 10'($urandom());
            end
        end
    endtask

    task automatic wait_empty();
        int w = 0;
        while (sb.size() != 0 && w < 60) begin
            step();
            w++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard: compare every output handshake of both instances.
    always @(negedge clk) begin
        sb_t e;
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out: got lane %0d data %h want nothing", out_lane, out_data);
            end else begin
                e = sb.pop_front();
                chk("data_sat", out_data, e.d1);
                chk("data_nosat", ns_out_data, e.d0);
                chk("ns_valid", {31'd0, ns_out_valid}, 32'd1);
                chk("lane", {30'd0, out_lane}, {30'd0, e.lane});
                chk("last", {31'd0, out_last}, {31'd0, e.lane == 2'd3});
                if (e.lane == 2'd3) begin
                    last_hs_cyc = cyc + 1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2;
        add(0, 0, 32'h4000_0000, 10'd127, 32'h3F80_0000, 32'h3F80_0000);
        add(0, 1, 32'hC000_0000, 10'd127, 32'hBF80_0000, 32'hBF80_0000);
        add(0, 2, 32'h0000_0000, 10'd5,   32'h0000_0000, 32'h0000_0000);
        add(0, 3, 32'h8000_0000, 10'd127, 32'hC000_0000, 32'hC000_0000);
        add(1, 0, 32'h4000_0040, 10'd127, 32'h3F80_0000, 32'h3F80_0000);
        add(1, 1, 32'h4000_00C0, 10'd127, 32'h3F80_0002, 32'h3F80_0002);
        add(1, 2, 32'h4000_0041, 10'd127, 32'h3F80_0001, 32'h3F80_0001);
        add(1, 3, 32'h7FFF_FFFF, 10'd127, 32'h4000_0000, 32'h4000_0000);
        add(2, 0, 32'h4000_0000, 10'h3FF, 32'h7F80_0000, 32'h7F7F_FFFF);
        add(2, 1, 32'h4000_0000, 10'd0,   32'h0000_0000, 32'h0000_0000);
        add(2, 2, 32'hC000_0000, 10'd0,   32'h8000_0000, 32'h8000_0000);
        add(2, 3, 32'hC000_0000, 10'h3FF, 32'hFF80_0000, 32'hFF7F_FFFF);
        add(3, 0, 32'h2000_0000, 10'd127, 32'h3F00_0000, 32'h3F00_0000);
        add(3, 1, 32'h0000_0001, 10'd127, 32'h3080_0000, 32'h3080_0000);
        add(3, 2, 32'hFFFF_FFFF, 10'd127, 32'hB080_0000, 32'hB080_0000);
        add(3, 3, 32'h6000_0000, 10'd130, 32'h4140_0000, 32'h4140_0000);
        add(4, 0, 32'h4000_0000, 10'd254, 32'h7F00_0000, 32'h7F00_0000);
        add(4, 1, 32'h4000_0000, 10'd255, 32'h7F80_0000, 32'h7F7F_FFFF);
        add(4, 2, 32'h7FFF_FFFF, 10'd254, 32'h7F80_0000, 32'h7F7F_FFFF);
        add(4, 3, 32'h4000_0000, 10'd1,   32'h0080_0000, 32'h0080_0000);

        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            acc_d[k] = 32'd0;
            exp_d[k] = 10'd0;
        end
        repeat (3) step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        step();
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Table pass with latency and in_ready timing checks.
        for (int v = 0; v < 5; v++) begin
            send_bank(v, 1'b0, c1);
            step();
            chk("lat_n1_valid", {31'd0, out_valid}, 32'd0);
            for (int k = 0; k < 4; k++) begin
                step();
                chk("lat_lane_valid", {31'd0, out_valid}, 32'd1);
                chk("lat_in_ready_low", {31'd0, in_ready}, 32'd0);
            end
            step();
            chk("in_ready_after_last", {31'd0, in_ready}, 32'd1);
            wait_empty();
        end

        // Backpressure: stall with lane 1 presented.
        send_bank(1, 1'b0, c1);
        repeat (3) step();
        chk("bp_lane1_shown", {30'd0, out_lane}, 32'd1);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_lane", {30'd0, out_lane}, 32'd1);
            chk("bp_data", out_data, 32'h3F80_0002);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        for (int w = 0; w < 40 && sb.size() != 0; w++) begin
            chk("bp_drain_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        wait_empty();

        // Reset while lane 1 is pending.
        send_bank(0, 1'b0, c1);
        repeat (3) step();
        reset = 1'b0;
        step();
        sb.delete();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_lane", {30'd0, out_lane}, 32'd0);
        chk("mid_rst_last", {31'd0, out_last}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("post_rst_quiet", {31'd0, out_valid}, 32'd0);
        end
        send_bank(3, 1'b0, c1);
        wait_empty();

        // Back-to-back banks with in_valid held high.
        send_bank(1, 1'b1, c1);
        send_bank(4, 1'b0, c2);
        chk("b2b_accept_cycle", 32'(c2), 32'(last_hs_cyc + 1));
        wait_empty();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
